uart_tx_fifo_cfg: RTL and testbench

Parametrised successor to the team's fixed 8N1 TX-FIFO transmitter. Combines a configurable-depth TX FIFO with a frame engine supporting 5–9 data bits, none/even/odd parity, and 1 or 2 stop bits. Adds level, almost-full and overflow reporting. Sits between the host write interface and the serial TX pin, driven by the shared baud tick generator.

---
 rtl/uart_tx_fifo_cfg_if.sv | 23 ++
 rtl/uart_tx_fifo_cfg.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_fifo_cfg.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_cfg_if.sv
// Host write-side bundle for uart_tx_fifo_cfg: write data/strobe plus FIFO status flags.
interface uart_tx_fifo_cfg_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_BITS-1:0]       tx_data_in;
  logic                       tx_write;
  logic                       tx_full;
  logic                       tx_empty;
  logic [$clog2(FIFO_DEPTH):0] tx_level;
  logic                       tx_almost_full;
  logic                       tx_overflow;

  modport master (
    output tx_data_in, tx_write,
    input  tx_full, tx_empty, tx_level, tx_almost_full, tx_overflow
  );

  modport slave (
    input  tx_data_in, tx_write,
    output tx_full, tx_empty, tx_level, tx_almost_full, tx_overflow
  );
endinterface

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter: TX FIFO plus 5..9 data bit frame engine with optional parity and 1/2 stop bits.
// Optional macro UART_TX_BREAK_EN adds tx_break (hold line low between frames while asserted).
//
// state    | meaning
// S_IDLE   | line high, waiting for a tick with queued data
// S_START  | start bit (low) on the line
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit on the line
// S_STOP   | stop bit(s), high
// S_BREAK  | break: line held low (break build only)
// S_MARK   | one full high bit period after break (break build only)
module uart_tx_fifo_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int AF_THRESH   = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              baud_tick,
`ifdef UART_TX_BREAK_EN
  input  logic              tx_break,
`endif
  uart_tx_fifo_cfg_if.slave host,
  output logic              tx,
  output logic              tx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 4;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be in 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("AF_THRESH must be in 1..FIFO_DEPTH");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK, S_MARK
`endif
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 overflow;
  logic                 full, empty, push, load;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 par_bit, par_nxt, tx_nxt, busy_nxt;

  // Flags come from the level register only, so tx_write never reaches them combinationally.
  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign push  = host.tx_write && !full;
  assign head  = mem[rd_ptr];

  assign host.tx_full        = full;
  assign host.tx_empty       = empty;
  assign host.tx_level       = level;
  assign host.tx_almost_full = (level >= LW'(AF_THRESH));
  assign host.tx_overflow    = overflow;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host.tx_data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      level    <= level + LW'(push) - LW'(load);
      overflow <= host.tx_write && full;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    par_nxt   = par_bit;
    tx_nxt    = tx;
    busy_nxt  = tx_busy;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (baud_tick && tx_break) begin
          state_nxt = S_BREAK;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
        end else
`endif
        if (baud_tick && !empty) load = 1'b1;
      end
      S_START: if (baud_tick) begin
        state_nxt = S_DATA;
        tx_nxt    = shreg[0];
        cnt_nxt   = CW'(DATA_BITS - 1);
      end
      S_DATA: if (baud_tick) begin
        if (cnt != '0) begin
          shreg_nxt = shreg >> 1;
          tx_nxt    = shreg[1];
          cnt_nxt   = cnt - 1'b1;
        end else if (PARITY_MODE != 0) begin
          state_nxt = S_PARITY;
          tx_nxt    = par_bit;
        end else begin
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
          cnt_nxt   = CW'(STOP_BITS - 1);
        end
      end
      S_PARITY: if (baud_tick) begin
        state_nxt = S_STOP;
        tx_nxt    = 1'b1;
        cnt_nxt   = CW'(STOP_BITS - 1);
      end
      S_STOP: if (baud_tick) begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
`ifdef UART_TX_BREAK_EN
        else if (tx_break) begin
          state_nxt = S_BREAK;
          tx_nxt    = 1'b0;
        end
`endif
        else if (!empty) load = 1'b1;
        else begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end
      end
`ifdef UART_TX_BREAK_EN
      // Line rises as soon as break drops; the first tick then opens one full high period.
      S_BREAK: if (!tx_break) begin
        state_nxt = S_MARK;
        tx_nxt    = 1'b1;
        cnt_nxt   = CW'(1);
      end
      S_MARK: if (baud_tick) begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else if (tx_break) begin
          state_nxt = S_BREAK;
          tx_nxt    = 1'b0;
        end else if (!empty) load = 1'b1;
        else begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
    // Pop and start bit share one edge; back-to-back frames reuse this path from S_STOP.
    if (load) begin
      state_nxt = S_START;
      shreg_nxt = head;
      par_nxt   = (PARITY_MODE == 2) ? ~^head : ^head;
      cnt_nxt   = '0;
      tx_nxt    = 1'b0;
      busy_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      par_bit <= par_nxt;
      tx      <= tx_nxt;
      tx_busy <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: three parameter sets driven together, compared against a queue-based frame model.
module tb_uart_tx_fifo_cfg;
  localparam int N = 3;
  localparam int DB  [N] = '{8, 7, 8};
  localparam int DEP [N] = '{16, 4, 2};
  localparam int PM  [N] = '{0, 1, 2};
  localparam int SB  [N] = '{1, 2, 1};
  localparam int AFT [N] = '{12, 3, 1};

  logic clk = 1'b0;
  logic reset_n;
  logic baud_tick;
  logic tx_o   [N];
  logic busy_o [N];
  logic [N-1:0] full_o, empty_o, af_o, ovf_o;
  int lvl [N];

  uart_tx_fifo_cfg_if #(.DATA_BITS(DB[0]), .FIFO_DEPTH(DEP[0])) if0 ();
  uart_tx_fifo_cfg_if #(.DATA_BITS(DB[1]), .FIFO_DEPTH(DEP[1])) if1 ();
  uart_tx_fifo_cfg_if #(.DATA_BITS(DB[2]), .FIFO_DEPTH(DEP[2])) if2 ();

  uart_tx_fifo_cfg #(.DATA_BITS(DB[0]), .FIFO_DEPTH(DEP[0]), .PARITY_MODE(PM[0]),
                     .STOP_BITS(SB[0]), .AF_THRESH(AFT[0])) u_dut0 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .host(if0),
    .tx(tx_o[0]), .tx_busy(busy_o[0]));
  uart_tx_fifo_cfg #(.DATA_BITS(DB[1]), .FIFO_DEPTH(DEP[1]), .PARITY_MODE(PM[1]),
                     .STOP_BITS(SB[1]), .AF_THRESH(AFT[1])) u_dut1 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .host(if1),
    .tx(tx_o[1]), .tx_busy(busy_o[1]));
  uart_tx_fifo_cfg #(.DATA_BITS(DB[2]), .FIFO_DEPTH(DEP[2]), .PARITY_MODE(PM[2]),
                     .STOP_BITS(SB[2]), .AF_THRESH(AFT[2])) u_dut2 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .host(if2),
    .tx(tx_o[2]), .tx_busy(busy_o[2]));

  assign full_o  = {if2.tx_full, if1.tx_full, if0.tx_full};
  assign empty_o = {if2.tx_empty, if1.tx_empty, if0.tx_empty};
  assign af_o    = {if2.tx_almost_full, if1.tx_almost_full, if0.tx_almost_full};
  assign ovf_o   = {if2.tx_overflow, if1.tx_overflow, if0.tx_overflow};
  assign lvl[0]  = int'(if0.tx_level);
  assign lvl[1]  = int'(if1.tx_level);
  assign lvl[2]  = int'(if2.tx_level);

  always #5 clk = ~clk;

  int checks, failures, ovf_cnt1;
  int fq  [N][$];   // words waiting in the FIFO
  int bq  [N][$];   // line levels still to be sent for the current frame
  int cap [N][$];   // line level sampled after each tick
  logic exp_tx [N], exp_busy [N], exp_ovf [N];

  int exp_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int exp_55 [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
  int exp_3c [10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      fq[k].delete();
      bq[k].delete();
      exp_tx[k]   = 1'b1;
      exp_busy[k] = 1'b0;
      exp_ovf[k]  = 1'b0;
    end
  endtask

  // One clock edge of the model: full/empty judged on the occupancy before the edge.
  task automatic model_edge(input int k, input bit tick, input bit wr, input int d);
    bit full_pre, empty_pre;
    int v;
    full_pre  = (fq[k].size() == DEP[k]);
    empty_pre = (fq[k].size() == 0);
    exp_ovf[k] = wr && full_pre;
    if (tick) begin
      if (bq[k].size() == 0 && !empty_pre) begin
        v = fq[k].pop_front();
        bq[k].push_back(0);
        for (int i = 0; i < DB[k]; i++) bq[k].push_back((v >> i) & 1);
        if (PM[k] != 0) bq[k].push_back(($countones(v) % 2) ^ (PM[k] == 2 ? 1 : 0));
        for (int i = 0; i < SB[k]; i++) bq[k].push_back(1);
      end
      if (bq[k].size() != 0) begin
        v = bq[k].pop_front();
        exp_tx[k]   = (v != 0);
        exp_busy[k] = 1'b1;
      end else begin
        exp_tx[k]   = 1'b1;
        exp_busy[k] = 1'b0;
      end
    end
    if (wr && !full_pre) fq[k].push_back(d & ((1 << DB[k]) - 1));
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_d%0d_tx", ph, k), tx_o[k], exp_tx[k]);
      chk($sformatf("%s_d%0d_busy", ph, k), busy_o[k], exp_busy[k]);
      chk($sformatf("%s_d%0d_level", ph, k), lvl[k], fq[k].size());
      chk($sformatf("%s_d%0d_empty", ph, k), empty_o[k], fq[k].size() == 0);
      chk($sformatf("%s_d%0d_full", ph, k), full_o[k], fq[k].size() == DEP[k]);
      chk($sformatf("%s_d%0d_af", ph, k), af_o[k], fq[k].size() >= AFT[k]);
      chk($sformatf("%s_d%0d_ovf", ph, k), ovf_o[k], exp_ovf[k]);
    end
  endtask

  task automatic step(input bit tick, input bit [N-1:0] wr, input int d0, input int d1, input int d2);
    @(negedge clk);
    baud_tick = tick;
    if0.tx_write = wr[0]; if0.tx_data_in = d0[DB[0]-1:0];
    if1.tx_write = wr[1]; if1.tx_data_in = d1[DB[1]-1:0];
    if2.tx_write = wr[2]; if2.tx_data_in = d2[DB[2]-1:0];
    @(posedge clk);
    model_edge(0, tick, wr[0], d0);
    model_edge(1, tick, wr[1], d1);
    model_edge(2, tick, wr[2], d2);
    #1;
    check_all("cyc");
    for (int k = 0; k < N; k++) if (tick) cap[k].push_back(int'(tx_o[k]));
    if (ovf_o[1]) ovf_cnt1++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, '0, 0, 0, 0);
      step(1'b0, '0, 0, 0, 0);
      step(1'b0, '0, 0, 0, 0);
    end
  endtask

  task automatic clear_cap();
    for (int k = 0; k < N; k++) cap[k].delete();
  endtask

  initial begin
    int v;
    bit tk;
    bit [N-1:0] wr;
    checks = 0; failures = 0; ovf_cnt1 = 0;
    reset_n = 1'b0; baud_tick = 1'b0;
    if0.tx_write = 1'b0; if0.tx_data_in = '0;
    if1.tx_write = 1'b0; if1.tx_data_in = '0;
    if2.tx_write = 1'b0; if2.tx_data_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;

    // Fill with tick low: dut1 (depth 4) overflows on its fifth write, dut2 holds two words.
    step(1'b0, 3'b111, 'hA5, 'h11, 'h00);
    step(1'b0, 3'b110, 0, 'h22, 'h01);
    step(1'b0, 3'b010, 0, 'h33, 0);
    step(1'b0, 3'b010, 0, 'h44, 0);
    step(1'b0, 3'b010, 0, 'h55, 0);
    step(1'b0, 3'b000, 0, 0, 0);
    chk("ovf_pulses", ovf_cnt1, 1);

    clear_cap();
    ticks(46);
    for (int i = 0; i < 10; i++) chk($sformatf("a5_bit%0d", i), cap[0][i], exp_a5[i]);
    chk("a5_idle_after", cap[0][10], 1);
    for (int j = 0; j < 4; j++) begin
      v = 0;
      for (int i = 0; i < 7; i++) v |= (cap[1][11*j + 1 + i] & 1) << i;
      chk($sformatf("b2b_frame%0d", j), v, 'h11 * (j + 1));
      chk($sformatf("b2b_start%0d", j), cap[1][11*j], 0);
    end
    chk("dropped_not_sent", cap[1][44], 1);
    chk("odd_par_00", cap[2][9], 1);
    chk("odd_par_01", cap[2][20], 0);

    clear_cap();
    step(1'b0, 3'b010, 0, 'h55, 0);
    ticks(12);
    for (int i = 0; i < 11; i++) chk($sformatf("7e2_bit%0d", i), cap[1][i], exp_55[i]);
    chk("7e2_idle_after", cap[1][11], 1);

    // Reset while dut0 is driving its fourth data bit, with one more word still queued.
    step(1'b0, 3'b001, 'h5A, 0, 0);
    step(1'b0, 3'b001, 'h77, 0, 0);
    ticks(5);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_tx", tx_o[0], 1'b1);
    chk("midrst_busy", busy_o[0], 1'b0);
    chk("midrst_level", lvl[0], 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    clear_cap();
    step(1'b0, 3'b001, 'h3C, 0, 0);
    ticks(11);
    for (int i = 0; i < 10; i++) chk($sformatf("3c_bit%0d", i), cap[0][i], exp_3c[i]);
    chk("3c_idle_after", cap[0][10], 1);

    for (int c = 0; c < 1500; c++) begin
      tk = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) wr[k] = ($urandom_range(0, 9) < (c < 750 ? 5 : 1));
      step(tk, wr, int'($urandom), int'($urandom), int'($urandom));
    end

    ticks(200);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("drain_d%0d_empty", k), empty_o[k], 1'b1);
      chk($sformatf("drain_d%0d_busy", k), busy_o[k], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
